// File: rtl/prefilter_pkg.sv
// Shared types and constants for the pre-filter bank router.
package prefilter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01
    } state_e;

    localparam logic MODE_RR    = 1'b0;
    localparam logic MODE_BCAST = 1'b1;

endpackage

// File: rtl/prefilter_blk_counter.sv
// Sample-within-block counter with terminal-count flag, plus the bank index
// that advances (and wraps) when a block completes.
module prefilter_blk_counter
    import prefilter_pkg::*;
#(
    parameter int unsigned LEN_W     = 13,
    parameter int unsigned NUM_BANKS = 2,
    parameter int unsigned BANK_W    = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ce,
    input  logic              clear,
    input  logic              accept,
    input  logic              bank_adv_en,
    input  logic [LEN_W-1:0]  len,
    output logic              tc,
    output logic [BANK_W-1:0] bank
);

    localparam logic [BANK_W-1:0] LastBank = BANK_W'(NUM_BANKS - 1);

    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [BANK_W-1:0] bank_q, bank_d;

    // len is never 0 (clamped on latch), so len-1 cannot underflow.
    assign tc   = (cnt_q == len - LEN_W'(1));
    assign bank = bank_q;

    always_comb begin
        cnt_d  = cnt_q;
        bank_d = bank_q;
        if (clear) begin
            cnt_d  = '0;
            bank_d = '0;
        end else if (accept) begin
            if (tc) begin
                cnt_d = '0;
                if (bank_adv_en) begin
                    bank_d = (bank_q == LastBank) ? '0 : bank_q + BANK_W'(1);
                end
            end else begin
                cnt_d = cnt_q + LEN_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            bank_q <= '0;
        end else if (ce) begin
            cnt_q  <= cnt_d;
            bank_q <= bank_d;
        end
    end

endmodule

// File: rtl/prefilter_bank_router.sv
// Steers packer samples into NUM_BANKS pre-filter FIFO banks, round-robin per
// block or broadcast, with full backpressure, block-done pulse and sticky overflow.
module prefilter_bank_router
    import prefilter_pkg::*;
#(
    parameter  int unsigned NUM_BANKS   = 2,
    parameter  int unsigned WR_PER_BANK = 2,
    parameter  int unsigned LEN_W       = 13,
    localparam int unsigned BANK_W      = $clog2(NUM_BANKS)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             ce,
    input  logic                             enable,
    input  logic                             mode,
    input  logic [LEN_W-1:0]                 packer_len,
    input  logic                             blk_rdy,
    input  logic [NUM_BANKS-1:0]             bank_full,
    input  logic                             overflow_clr,
    output logic [NUM_BANKS*WR_PER_BANK-1:0] fifo_wr,
    output logic [BANK_W-1:0]                cur_bank,
    output logic                             block_done,
    output logic                             overflow
);

    state_e state_q, state_d;

    logic [LEN_W-1:0]  len_q;
    logic              mode_q;
    logic [BANK_W-1:0] bank;
    logic              tc;
    logic              run;
    logic              tfull;
    logic              accept;
    logic              drop;
    logic              wr_en;
    logic              block_done_d, block_done_q;
    logic              overflow_d, overflow_q;

    logic [NUM_BANKS-1:0]             target;
    logic [NUM_BANKS*WR_PER_BANK-1:0] fifo_wr_d, fifo_wr_q;

    // Dropping enable aborts the run, so it masks any write in the same cycle.
    assign run    = (state_q == RUN) && enable;
    assign tfull  = |(target & bank_full);
    assign accept = run && blk_rdy && !tfull;
    assign drop   = run && blk_rdy && tfull;

    prefilter_blk_counter #(
        .LEN_W     (LEN_W),
        .NUM_BANKS (NUM_BANKS),
        .BANK_W    (BANK_W)
    ) u_blk_counter (
        .clk         (clk),
        .reset       (reset),
        .ce          (ce),
        .clear       (!run),
        .accept      (accept),
        .bank_adv_en (mode_q == MODE_RR),
        .len         (len_q),
        .tc          (tc),
        .bank        (bank)
    );

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        assign target[b] = (mode_q == MODE_BCAST) || (bank == BANK_W'(b));
        assign fifo_wr_d[b*WR_PER_BANK +: WR_PER_BANK] = {WR_PER_BANK{wr_en && target[b]}};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else if (ce) begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (enable) state_d = RUN;
            RUN:     if (!enable) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_en        = 1'b0;
        block_done_d = 1'b0;
        overflow_d   = overflow_q;
        if (accept) begin
            wr_en        = 1'b1;
            block_done_d = tc;
        end
        if (drop) begin
            overflow_d = 1'b1;
        end else if (overflow_clr) begin
            overflow_d = 1'b0;
        end
    end

    // Block length and mode are frozen for the whole run.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len_q  <= LEN_W'(1);
            mode_q <= MODE_RR;
        end else if (ce && state_q == IDLE && enable) begin
            len_q  <= (packer_len == '0) ? LEN_W'(1) : packer_len;
            mode_q <= mode;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fifo_wr_q    <= '0;
            block_done_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else if (ce) begin
            fifo_wr_q    <= fifo_wr_d;
            block_done_q <= block_done_d;
            overflow_q   <= overflow_d;
        end else begin
            fifo_wr_q    <= '0;
            block_done_q <= 1'b0;
        end
    end

    assign fifo_wr    = fifo_wr_q;
    assign cur_bank   = bank;
    assign block_done = block_done_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_prefilter_bank_router.sv
// Scoreboard bench: a 3-bank and a 4-bank router share stimulus; a behavioural
// model per instance pushes expected outputs that are popped after each edge.
module tb_prefilter_bank_router;

    typedef struct packed {
        logic [7:0] wr;
        logic [1:0] bank;
        logic       done;
        logic       ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        ce;
    logic        enable;
    logic        mode;
    logic [12:0] packer_len;
    logic        blk_rdy;
    logic [3:0]  bank_full;
    logic        overflow_clr;

    logic [5:0] wr3;
    logic [1:0] bank3;
    logic       done3, ovf3;
    logic [7:0] wr4;
    logic [1:0] bank4;
    logic       done4, ovf4;

    int n_checks = 0;
    int n_errors = 0;

    exp_t sb3[$];
    exp_t sb4[$];

    bit m_run[2];
    int m_cnt[2];
    int m_bank[2];
    int m_len[2];
    bit m_mode[2];
    bit m_ovf[2];

    always #5 clk = ~clk;

    prefilter_bank_router #(
        .NUM_BANKS   (3),
        .WR_PER_BANK (2),
        .LEN_W       (13)
    ) dut3 (
        .clk          (clk),
        .reset        (reset),
        .ce           (ce),
        .enable       (enable),
        .mode         (mode),
        .packer_len   (packer_len),
        .blk_rdy      (blk_rdy),
        .bank_full    (bank_full[2:0]),
        .overflow_clr (overflow_clr),
        .fifo_wr      (wr3),
        .cur_bank     (bank3),
        .block_done   (done3),
        .overflow     (ovf3)
    );

    prefilter_bank_router #(
        .NUM_BANKS   (4),
        .WR_PER_BANK (2),
        .LEN_W       (13)
    ) dut4 (
        .clk          (clk),
        .reset        (reset),
        .ce           (ce),
        .enable       (enable),
        .mode         (mode),
        .packer_len   (packer_len),
        .blk_rdy      (blk_rdy),
        .bank_full    (bank_full),
        .overflow_clr (overflow_clr),
        .fifo_wr      (wr4),
        .cur_bank     (bank4),
        .block_done   (done4),
        .overflow     (ovf4)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_run[i]  = 1'b0;
            m_cnt[i]  = 0;
            m_bank[i] = 0;
            m_len[i]  = 1;
            m_mode[i] = 1'b0;
            m_ovf[i]  = 1'b0;
        end
        sb3.delete();
        sb4.delete();
    endtask

    // Expected outputs after the coming rising edge, given the current inputs.
    task automatic model_step(input int i, input int nb, output exp_t e);
        logic [3:0] bf;
        logic       full_t;
        e  = '0;
        bf = bank_full & 4'((1 << nb) - 1);
        if (ce) begin
            if (!m_run[i]) begin
                if (enable) begin
                    m_run[i]  = 1'b1;
                    m_len[i]  = (packer_len == 0) ? 1 : int'(packer_len);
                    m_mode[i] = mode;
                end
                m_cnt[i]  = 0;
                m_bank[i] = 0;
                if (overflow_clr) m_ovf[i] = 1'b0;
            end else if (!enable) begin
                m_run[i]  = 1'b0;
                m_cnt[i]  = 0;
                m_bank[i] = 0;
                if (overflow_clr) m_ovf[i] = 1'b0;
            end else begin
                full_t = m_mode[i] ? (|bf) : bf[m_bank[i]];
                if (blk_rdy && full_t) m_ovf[i] = 1'b1;
                else if (overflow_clr) m_ovf[i] = 1'b0;
                if (blk_rdy && !full_t) begin
                    for (int b = 0; b < nb; b++) begin
                        if (m_mode[i] || b == m_bank[i]) e.wr[b*2 +: 2] = 2'b11;
                    end
                    if (m_cnt[i] == m_len[i] - 1) begin
                        m_cnt[i] = 0;
                        e.done   = 1'b1;
                        if (!m_mode[i]) m_bank[i] = (m_bank[i] + 1) % nb;
                    end else begin
                        m_cnt[i]++;
                    end
                end
            end
        end
        e.bank = 2'(m_bank[i]);
        e.ovf  = m_ovf[i];
    endtask

    task automatic compare();
        exp_t e;
        check_eq("sb3_depth", sb3.size(), 1);
        if (sb3.size() > 0) begin
            e = sb3.pop_front();
            check_eq("wr3", {26'd0, wr3}, {24'd0, e.wr});
            check_eq("bank3", {30'd0, bank3}, {30'd0, e.bank});
            check_eq("done3", {31'd0, done3}, {31'd0, e.done});
            check_eq("ovf3", {31'd0, ovf3}, {31'd0, e.ovf});
        end
        check_eq("sb4_depth", sb4.size(), 1);
        if (sb4.size() > 0) begin
            e = sb4.pop_front();
            check_eq("wr4", {24'd0, wr4}, {24'd0, e.wr});
            check_eq("bank4", {30'd0, bank4}, {30'd0, e.bank});
            check_eq("done4", {31'd0, done4}, {31'd0, e.done});
            check_eq("ovf4", {31'd0, ovf4}, {31'd0, e.ovf});
        end
    endtask

    task automatic step();
        exp_t e;
        model_step(0, 3, e);
        sb3.push_back(e);
        model_step(1, 4, e);
        sb4.push_back(e);
        @(posedge clk);
        #1;
        compare();
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_wr3"}, {26'd0, wr3}, 32'd0);
        check_eq({tag, "_bank3"}, {30'd0, bank3}, 32'd0);
        check_eq({tag, "_done3"}, {31'd0, done3}, 32'd0);
        check_eq({tag, "_ovf3"}, {31'd0, ovf3}, 32'd0);
        check_eq({tag, "_wr4"}, {24'd0, wr4}, 32'd0);
        check_eq({tag, "_bank4"}, {30'd0, bank4}, 32'd0);
        check_eq({tag, "_done4"}, {31'd0, done4}, 32'd0);
        check_eq({tag, "_ovf4"}, {31'd0, ovf4}, 32'd0);
    endtask

    // Reset asserted between edges: outputs must clear without waiting for a clock.
    task automatic async_reset();
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("async_rst");
        model_reset();
        @(posedge clk);
        #1;
        check_all_zero("rst_hold");
        reset = 1'b0;
    endtask

    initial begin
        reset        = 1'b1;
        ce           = 1'b1;
        enable       = 1'b0;
        mode         = 1'b0;
        packer_len   = 13'd4;
        blk_rdy      = 1'b0;
        bank_full    = 4'd0;
        overflow_clr = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b0;

        // Round-robin, continuous samples, 4 per block.
        enable  = 1'b1;
        blk_rdy = 1'b1;
        repeat (16) step();
        enable = 1'b0;
        repeat (2) step();

        // Gapped samples, 3 per block.
        packer_len = 13'd3;
        enable     = 1'b1;
        for (int k = 0; k < 20; k++) begin
            blk_rdy = (k % 2 == 0);
            step();
        end

        // Full bank 1 while it is the current bank.
        enable = 1'b0;
        step();
        enable  = 1'b1;
        blk_rdy = 1'b1;
        repeat (4) step();
        bank_full = 4'b0010;
        repeat (2) step();
        bank_full    = 4'd0;
        blk_rdy      = 1'b0;
        overflow_clr = 1'b1;
        step();
        overflow_clr = 1'b0;
        blk_rdy      = 1'b1;
        repeat (3) step();

        // Broadcast, 2 per block, then backpressure from one bank.
        enable = 1'b0;
        step();
        mode       = 1'b1;
        packer_len = 13'd2;
        enable     = 1'b1;
        repeat (6) step();
        bank_full = 4'b0100;
        repeat (2) step();
        bank_full = 4'b1000;
        step();
        bank_full    = 4'd0;
        overflow_clr = 1'b1;
        step();
        overflow_clr = 1'b0;
        repeat (2) step();

        // Abort a 5-sample block at cnt=2, re-enable with a new length.
        enable = 1'b0;
        step();
        mode       = 1'b0;
        packer_len = 13'd5;
        enable     = 1'b1;
        repeat (3) step();
        enable = 1'b0;
        step();
        packer_len = 13'd2;
        repeat (2) step();
        enable = 1'b1;
        repeat (8) step();

        // Clock enable low mid-run.
        ce = 1'b0;
        repeat (3) step();
        ce = 1'b1;
        repeat (3) step();

        // Reset mid-block while writing, then zero length behaves as one.
        async_reset();
        packer_len = 13'd0;
        repeat (8) step();

        // Random traffic.
        for (int k = 0; k < 120; k++) begin
            blk_rdy      = ($urandom_range(3) != 0);
            bank_full    = ($urandom_range(4) == 0) ? 4'($urandom_range(15)) : 4'd0;
            overflow_clr = ($urandom_range(5) == 0);
            enable       = ($urandom_range(19) != 0);
            ce           = ($urandom_range(9) != 0);
            mode         = ($urandom_range(7) == 0) ? ~mode : mode;
            packer_len   = 13'($urandom_range(3));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
